frame_sync_cfg_ctrl: RTL and testbench

//   Key-driven configuration controller for the edge-detection pipeline. Turns debounced key events into
//   a display mode and a Sobel threshold level. Auto-repeats held up/down keys. Stages every change in

---
 rtl/frame_sync_cfg_ctrl.sv | 175 +++++++++++++++++
 tb/tb_frame_sync_cfg_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_cfg_ctrl.sv
// frame_sync_cfg_ctrl: key-driven display mode / Sobel threshold controller.
// Key events edit a shadow configuration (with auto-repeat for held up/down
// keys); the shadow is copied to the active outputs only on a vsync rising
// edge so the video path never sees a mid-frame change.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   key_flag          1-cycle debounced key press pulse
//   key_value[3:0]    key code, valid with key_flag
//   key_down[3:0]     debounced key levels (1 = pressed)
//   frame_vsync       frame sync, active-high
//   mode[1:0]         active display mode
//   level[3:0]        active threshold level
//   sobel_threshold   active threshold, saturated at 255
//   cfg_update        1-cycle pulse when a changed config is committed
//   cfg_pending       shadow config differs from active config
module frame_sync_cfg_ctrl #(
  parameter int unsigned LEVEL_MAX     = 7,
  parameter int unsigned DEF_LEVEL     = 3,
  parameter int unsigned THRESH_BASE   = 20,
  parameter int unsigned THRESH_STEP   = 10,
  parameter int unsigned MODE_NUM      = 3,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_flag,
  input  logic [3:0] key_value,
  input  logic [3:0] key_down,
  input  logic       frame_vsync,
  output logic [1:0] mode,
  output logic [3:0] level,
  output logic [7:0] sobel_threshold,
  output logic       cfg_update,
  output logic       cfg_pending
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] KEY_MODE = 4'b0001;
  localparam logic [3:0] KEY_DEF  = 4'b0010;
  localparam logic [3:0] KEY_DN   = 4'b0100;
  localparam logic [3:0] KEY_UP   = 4'b1000;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       sh_level_q, sh_level_d;
  logic [1:0]       sh_mode_q, sh_mode_d;
  logic [3:0]       level_q, level_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       thresh_q, thresh_d;
  logic             update_q, update_d;
  logic             pending_q, pending_d;
  logic             vs1_q, vs2_q;
  logic             vs_edge;
  logic             cfg_diff;

  // Saturating single level step in the direction of the key code.
  function automatic logic [3:0] step_level(input logic [3:0] lvl, input logic [3:0] code);
    if (code == KEY_UP) begin
      return (lvl >= 4'(LEVEL_MAX)) ? 4'(LEVEL_MAX) : lvl + 4'd1;
    end
    return (lvl == 4'd0) ? 4'd0 : lvl - 4'd1;
  endfunction

  // Threshold for a level, computed wide and clamped so it never wraps.
  function automatic logic [7:0] thresh_of(input logic [3:0] lvl);
    logic [15:0] full;
    full = 16'(THRESH_BASE) + 16'(lvl) * 16'(THRESH_STEP);
    return (full > 16'd255) ? 8'd255 : full[7:0];
  endfunction

  assign vs_edge  = vs1_q & ~vs2_q;
  assign cfg_diff = (sh_level_q != level_q) || (sh_mode_q != mode_q);

  // Key handling and auto-repeat; a new key_flag always overrides the timer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    sh_level_d = sh_level_q;
    sh_mode_d  = sh_mode_q;
    if (key_flag) begin
      state_d = IDLE;
      cnt_d   = '0;
      case (key_value)
        KEY_DN, KEY_UP: begin
          sh_level_d = step_level(sh_level_q, key_value);
          code_d     = key_value;
          state_d    = HOLD;
        end
        KEY_MODE: sh_mode_d = (sh_mode_q >= 2'(MODE_NUM - 1)) ? 2'd0 : sh_mode_q + 2'd1;
        KEY_DEF: begin
          sh_level_d = 4'(DEF_LEVEL);
          sh_mode_d  = 2'd0;
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        HOLD, REPEAT: begin
          if (key_down != code_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (((state_q == HOLD) && (cnt_q == CNT_W'(HOLD_CYCLES - 1))) ||
                       ((state_q == REPEAT) && (cnt_q == CNT_W'(REPEAT_CYCLES - 1)))) begin
            sh_level_d = step_level(sh_level_q, code_q);
            cnt_d      = '0;
            state_d    = REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Frame-boundary commit takes the shadow as it stood before this cycle's key step.
  always_comb begin
    level_d   = level_q;
    mode_d    = mode_q;
    thresh_d  = thresh_q;
    update_d  = 1'b0;
    pending_d = cfg_diff;
    if (vs_edge) begin
      level_d  = sh_level_q;
      mode_d   = sh_mode_q;
      thresh_d = thresh_of(sh_level_q);
      update_d = cfg_diff;
    end
  end

  // Vsync history resets high so a vsync already high at release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= 4'd0;
      sh_level_q <= 4'(DEF_LEVEL);
      sh_mode_q  <= 2'd0;
      level_q    <= 4'(DEF_LEVEL);
      mode_q     <= 2'd0;
      thresh_q   <= thresh_of(4'(DEF_LEVEL));
      update_q   <= 1'b0;
      pending_q  <= 1'b0;
      vs1_q      <= 1'b1;
      vs2_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      sh_level_q <= sh_level_d;
      sh_mode_q  <= sh_mode_d;
      level_q    <= level_d;
      mode_q     <= mode_d;
      thresh_q   <= thresh_d;
      update_q   <= update_d;
      pending_q  <= pending_d;
      vs1_q      <= frame_vsync;
      vs2_q      <= vs1_q;
    end
  end

  assign mode            = mode_q;
  assign level           = level_q;
  assign sobel_threshold = thresh_q;
  assign cfg_update      = update_q;
  assign cfg_pending     = pending_q;

endmodule

// File: tb/tb_frame_sync_cfg_ctrl.sv
// tb_frame_sync_cfg_ctrl: directed plus randomized checks of frame_sync_cfg_ctrl
// against a cycle-counting behavioural model of the key/commit rules.
module tb_frame_sync_cfg_ctrl;

  localparam int HOLD   = 20;
  localparam int REP    = 5;
  localparam int LMAX   = 7;
  localparam int DEFL   = 3;
  localparam int MODES  = 3;
  localparam logic [3:0] K_MODE = 4'b0001;
  localparam logic [3:0] K_DEF  = 4'b0010;
  localparam logic [3:0] K_DN   = 4'b0100;
  localparam logic [3:0] K_UP   = 4'b1000;

  logic       clk, rst, key_flag, frame_vsync;
  logic [3:0] key_value, key_down;
  logic [1:0] mode;
  logic [3:0] level;
  logic [7:0] sobel_threshold;
  logic       cfg_update, cfg_pending;

  int total = 0;
  int bad   = 0;

  // Model state: shadow/active config, held-key timing, vsync samples.
  int m_sh_lvl, m_sh_mode, m_act_lvl, m_act_mode, m_thr;
  bit m_held;
  logic [3:0] m_code;
  int m_elapsed;
  bit vs_prev1, vs_prev2;
  bit e_upd, e_pend;

  frame_sync_cfg_ctrl #(
    .LEVEL_MAX(LMAX), .DEF_LEVEL(DEFL), .THRESH_BASE(20), .THRESH_STEP(10),
    .MODE_NUM(MODES), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .key_value(key_value),
    .key_down(key_down), .frame_vsync(frame_vsync), .mode(mode), .level(level),
    .sobel_threshold(sobel_threshold), .cfg_update(cfg_update), .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int thr_of(input int l);
    int t;
    t = 20 + l * 10;
    return (t > 255) ? 255 : t;
  endfunction

  function automatic int stepped(input int l, input logic [3:0] code);
    if (code == K_UP) return (l >= LMAX) ? LMAX : l + 1;
    return (l <= 0) ? 0 : l - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit commit;
    if (rst) begin
      m_sh_lvl = DEFL; m_sh_mode = 0; m_act_lvl = DEFL; m_act_mode = 0;
      m_thr = thr_of(DEFL); m_held = 0; m_code = 4'd0; m_elapsed = 0;
      vs_prev1 = 1; vs_prev2 = 1; e_upd = 0; e_pend = 0;
      return;
    end
    commit = vs_prev1 && !vs_prev2;
    e_pend = (m_sh_lvl != m_act_lvl) || (m_sh_mode != m_act_mode);
    e_upd  = commit && e_pend;
    if (commit) begin
      m_act_lvl = m_sh_lvl; m_act_mode = m_sh_mode; m_thr = thr_of(m_sh_lvl);
    end
    vs_prev2 = vs_prev1;
    vs_prev1 = frame_vsync;
    if (key_flag) begin
      m_held = 0;
      if (key_value == K_UP || key_value == K_DN) begin
        m_sh_lvl = stepped(m_sh_lvl, key_value);
        m_held = 1; m_code = key_value; m_elapsed = 0;
      end else if (key_value == K_MODE) begin
        m_sh_mode = (m_sh_mode + 1) % MODES;
      end else if (key_value == K_DEF) begin
        m_sh_lvl = DEFL; m_sh_mode = 0;
      end
    end else if (m_held) begin
      if (key_down != m_code) m_held = 0;
      else begin
        m_elapsed++;
        if (m_elapsed >= HOLD && (m_elapsed - HOLD) % REP == 0)
          m_sh_lvl = stepped(m_sh_lvl, m_code);
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("mode", 32'(mode), 32'(m_act_mode));
    chk("level", 32'(level), 32'(m_act_lvl));
    chk("threshold", 32'(sobel_threshold), 32'(m_thr));
    chk("cfg_update", 32'(cfg_update), 32'(e_upd));
    chk("cfg_pending", 32'(cfg_pending), 32'(e_pend));
  endtask

  task automatic press(input logic [3:0] v);
    key_flag = 1'b1; key_value = v;
    cyc();
    key_flag = 1'b0; key_value = 4'd0;
  endtask

  task automatic vs_pulse();
    frame_vsync = 1'b1;
    cyc(); cyc(); cyc();
    frame_vsync = 1'b0;
    cyc();
  endtask

  initial begin
    logic [3:0] pick;
    rst = 1'b1; key_flag = 1'b0; key_value = 4'd0; key_down = 4'd0; frame_vsync = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    chk("reset_level", 32'(level), 32'd3);
    chk("reset_thr", 32'(sobel_threshold), 32'd50);
    chk("reset_pending", 32'(cfg_pending), 32'd0);
    frame_vsync = 1'b0;
    cyc();

    // Single up press, then commit.
    press(K_UP); cyc(); cyc();
    chk("single_pending", 32'(cfg_pending), 32'd1);
    vs_pulse();
    chk("single_level", 32'(level), 32'd4);
    chk("single_thr", 32'(sobel_threshold), 32'd60);

    // Held up key auto-repeats and saturates.
    key_down = K_UP;
    press(K_UP);
    repeat (40) cyc();
    key_down = 4'd0;
    cyc();
    vs_pulse();
    chk("hold_level", 32'(level), 32'd7);
    chk("hold_thr", 32'(sobel_threshold), 32'd90);

    // Down to 0, then a further down press changes nothing.
    repeat (8) begin press(K_DN); cyc(); end
    vs_pulse();
    chk("floor_level", 32'(level), 32'd0);
    press(K_DN); cyc();
    vs_pulse();
    chk("floor_hold", 32'(level), 32'd0);

    // Mode wraps after three presses.
    repeat (3) begin press(K_MODE); vs_pulse(); end
    chk("mode_wrap", 32'(mode), 32'd0);

    // Step in the same cycle as the commit edge stays pending.
    frame_vsync = 1'b1;
    cyc();
    press(K_UP);
    cyc();
    chk("same_cycle_level", 32'(level), 32'd0);
    chk("same_cycle_pending", 32'(cfg_pending), 32'd1);
    frame_vsync = 1'b0;
    cyc();
    vs_pulse();
    chk("same_cycle_commit", 32'(level), 32'd1);

    // Reset during auto-repeat discards pending state.
    key_down = K_UP;
    press(K_UP);
    repeat (27) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (30) cyc();
    key_down = 4'd0;
    vs_pulse();
    chk("rst_level", 32'(level), 32'd3);
    chk("rst_mode", 32'(mode), 32'd0);

    // Randomized phase.
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(399) == 0);
      if ($urandom_range(39) == 0) begin
        case ($urandom_range(4))
          0: key_down = 4'd0;
          1: key_down = K_UP;
          2: key_down = K_DN;
          default: key_down = 4'($urandom);
        endcase
      end
      if ($urandom_range(14) == 0) frame_vsync = ~frame_vsync;
      if ($urandom_range(24) == 0) begin
        case ($urandom_range(5))
          0: pick = K_MODE;
          1: pick = K_DEF;
          2: pick = 4'($urandom);
          default: pick = ($urandom_range(1) == 0) ? K_UP : K_DN;
        endcase
        if (key_down == K_UP || key_down == K_DN) begin
          if ($urandom_range(1) == 0) pick = key_down;
        end
        key_flag = 1'b1; key_value = pick;
      end else begin
        key_flag = 1'b0; key_value = 4'($urandom);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
